karatsuba_mulmod_pipe: RTL and testbench

Pipelined Karatsuba multiplier that returns `a*b mod (2^W - 1)` (Mersenne modulus) with valid/ready flow control and an opaque tag carried alongside each operation. It sits in the PageRank scoring datapath between the operand fetch stage and the accumulator/sort stage. It supersedes the fixed two-cycle raw-product multiplier: it supports backpressure, accepts one operation per cycle, and returns a canonically reduced W-bit residue instead of a 2W-bit product.

---
 rtl/karatsuba_mulmod_pipe.sv | 88 ++++++++
 tb/tb_karatsuba_mulmod_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mulmod_pipe.sv
// karatsuba_mulmod_pipe: 4-stage Karatsuba a*b mod (2^W-1) with valid/ready and tag sideband.
// Defining KMULMOD_STATS_EN adds saturating stat_ops/stat_stall counters.
module karatsuba_mulmod_pipe #(
  parameter int W = 61,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_p,
  output logic [TAG_W-1:0] out_tag
`ifdef KMULMOD_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_stall
`endif
);
  localparam int H = (W + 1) / 2;
  localparam int HS = H + 1;
  localparam int TM = 2 * H + 2;
  localparam int W2 = 2 * W;
  localparam int WS = W + 1;
  localparam logic [W-1:0] M = '1;
  logic adv;
  logic [H-1:0] a0, a1, b0, b1;
  logic [HS-1:0] sa, sb;
  logic [2*H-1:0] t1_c, t3_c;
  logic [TM-1:0] tm_c, mid_c;
  logic [W2-1:0] hl_c, p_c;
  logic [WS-1:0] s_c;
  logic [W-1:0] t_c;
  logic v1, v2, v3;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [2*H-1:0] t1_q, t3_q;
  logic [TM-1:0] tm_q, mid_q;
  logic [W2-1:0] hl_q;
  logic [WS-1:0] s_q;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign a0 = in_a[H-1:0];
  assign a1 = H'(in_a[W-1:H]);
  assign b0 = in_b[H-1:0];
  assign b1 = H'(in_b[W-1:H]);
  assign sa = HS'(a0) + HS'(a1);
  assign sb = HS'(b0) + HS'(b1);
  assign t1_c = (2*H)'(a1) * (2*H)'(b1);
  assign t3_c = (2*H)'(a0) * (2*H)'(b0);
  assign tm_c = TM'(sa) * TM'(sb);
  // cross terms are never negative: tm = t1 + t3 + a0*b1 + a1*b0
  assign mid_c = tm_q - TM'(t1_q) - TM'(t3_q);
  assign hl_c = (W2'(t1_q) << (2 * H)) + W2'(t3_q);
  assign p_c = hl_q + (W2'(mid_q) << H);
  // 2^W == 1 mod M, so the high half folds onto the low half
  assign s_c = WS'(p_c[W-1:0]) + WS'(p_c[W2-1:W]);
  assign t_c = s_q[W-1:0] + W'(s_q[W]);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {v1, v2, v3, out_valid} <= '0;
      {tag1, tag2, tag3, out_tag} <= '0;
      {t1_q, t3_q, tm_q} <= '0;
      {mid_q, hl_q} <= '0;
      s_q <= '0;
      out_p <= '0;
    end else if (adv) begin
      {v1, v2, v3, out_valid} <= {in_valid, v1, v2, v3};
      {tag1, tag2, tag3, out_tag} <= {in_tag, tag1, tag2, tag3};
      {t1_q, t3_q, tm_q} <= {t1_c, t3_c, tm_c};
      {mid_q, hl_q} <= {mid_c, hl_c};
      s_q <= s_c;
      out_p <= (t_c == M) ? '0 : t_c;
    end
`ifdef KMULMOD_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_ops <= '0;
      stat_stall <= '0;
    end else begin
      stat_ops <= (out_valid && out_ready && stat_ops != '1) ? stat_ops + 32'd1 : stat_ops;
      stat_stall <= (out_valid && !out_ready && stat_stall != '1) ? stat_stall + 32'd1 : stat_stall;
    end
`endif
endmodule

// File: tb/tb_karatsuba_mulmod_pipe.sv
// tb_karatsuba_mulmod_pipe: random + directed checks of karatsuba_mulmod_pipe at W=61 and W=7
// against a plain (a*b)%M queue model.
module tb_karatsuba_mulmod_pipe;
  localparam int W = 61;
  localparam logic [W-1:0] M = '1;
  typedef struct {
    logic [W-1:0] p;
    logic [7:0]   tag;
    int           cyc;
  } exp_t;
  typedef struct {
    logic [6:0] p;
    logic [7:0] tag;
  } exp7_t;
  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [W-1:0] in_a = '0, in_b = '0, out_p;
  logic [7:0] in_tag = '0, out_tag;
  logic in_valid7 = 0, in_ready7, out_valid7, out_ready7 = 1;
  logic [6:0] in_a7 = '0, in_b7 = '0, out_p7;
  logic [7:0] in_tag7 = '0, out_tag7;
`ifdef KMULMOD_STATS_EN
  logic [31:0] stat_ops, stat_stall, stat_ops7, stat_stall7;
`endif
  exp_t q[$];
  exp7_t q7[$];
  int errors = 0, checks = 0, cyc = 0, rdy_pct = 100;
  bit lat_chk = 1, pv = 0, pr = 0;
  logic [W-1:0] pp;
  logic [7:0] pt;

  always #5 clk = ~clk;

  karatsuba_mulmod_pipe #(.W(W), .TAG_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
`ifdef KMULMOD_STATS_EN
    , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
  );

  karatsuba_mulmod_pipe #(.W(7), .TAG_W(8)) dut7 (
    .clk(clk), .reset(reset), .in_valid(in_valid7), .in_ready(in_ready7),
    .in_a(in_a7), .in_b(in_b7), .in_tag(in_tag7), .out_valid(out_valid7),
    .out_ready(out_ready7), .out_p(out_p7), .out_tag(out_tag7)
`ifdef KMULMOD_STATS_EN
    , .stat_ops(stat_ops7), .stat_stall(stat_stall7)
`endif
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [127:0] prod;
    prod = {67'b0, x} * {67'b0, y};
    return W'(prod % {67'b0, M});
  endfunction

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 out_ready = ($urandom_range(99) < rdy_pct);
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) pv = 0;
    else begin
      chk("in_ready", 128'(in_ready), 128'(!out_valid || out_ready));
      if (pv && !pr) chk("stall_hold", {out_valid, out_p, out_tag}, {1'b1, pp, pt});
      if (out_valid && out_ready) begin
        chk("unexpected_out", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) begin
          chk("out_p", 128'(out_p), 128'(q[0].p));
          chk("out_tag", 128'(out_tag), 128'(q[0].tag));
          if (lat_chk) chk("latency", 128'(cyc - q[0].cyc), 128'(4));
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back('{model(in_a, in_b), in_tag, cyc});
      if (out_valid7) begin
        chk("unexpected_out7", 128'(q7.size() != 0), 128'(1));
        if (q7.size() != 0) begin
          chk("out_p7", 128'(out_p7), 128'(q7[0].p));
          chk("out_tag7", 128'(out_tag7), 128'(q7[0].tag));
          void'(q7.pop_front());
        end
      end
      if (in_valid7 && in_ready7) q7.push_back('{7'((int'(in_a7) * int'(in_b7)) % 127), in_tag7});
      pv = out_valid;
      pr = out_ready;
      pp = out_p;
      pt = out_tag;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [7:0] t);
    int n = 0;
    bit acc = 0;
    in_valid = 1;
    in_a = x;
    in_b = y;
    in_tag = t;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1 n++;
    end while (!acc && n < 1000);
    chk("accept_timeout", 128'(acc), 128'(1));
    in_valid = 0;
  endtask

  task automatic one_beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic [7:0] t,
                          input logic [W-1:0] expp);
    send(x, y, t);
    repeat (4) @(negedge clk);
    chk("beat_valid", 128'(out_valid), 128'(1));
    chk("beat_p", 128'(out_p), 128'(expp));
    chk("beat_tag", 128'(out_tag), 128'(t));
    @(negedge clk);
    chk("beat_single", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid || q7.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 128'(n < 3000), 128'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_p", 128'(out_p), 128'(0));
    chk("rst_tag", 128'(out_tag), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    reset = 0;
    @(posedge clk);
    #1;
    one_beat(61'd3, 61'd5, 8'h2A, 61'd15);
    one_beat(61'h1000_0000_0000_0000, 61'd2, 8'h01, 61'd1);
    one_beat(M, 61'd12345, 8'h02, 61'd0);
    one_beat(M - 61'd1, M - 61'd1, 8'h03, 61'd1);
    c0 = cyc;
    for (int i = 0; i < 1000; i++) send(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 8'(i));
    chk("throughput", 128'(cyc - c0), 128'(1000));
    drain();
    lat_chk = 0;
    rdy_pct = 30;
    for (int i = 0; i < 500; i++) begin
      send(W'({$urandom(), $urandom()}), ($urandom_range(7) == 0) ? M : W'({$urandom(), $urandom()}), 8'(i));
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rdy_pct = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(W'($urandom()), W'($urandom()), 8'(8'h80 + i));
    @(negedge clk);
    chk("fill_valid", 128'(out_valid), 128'(1));
    chk("fill_ready", 128'(in_ready), 128'(0));
    #2 reset = 1;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_p", 128'(out_p), 128'(0));
    chk("mid_rst_ready", 128'(in_ready), 128'(1));
    q.delete();
    rdy_pct = 100;
    @(negedge clk);
    #2 reset = 0;
    @(posedge clk);
    #1;
    lat_chk = 1;
    one_beat(61'd7, 61'd9, 8'h55, 61'd63);
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < 128; j++) begin
        in_valid7 = 1;
        in_a7 = 7'(i);
        in_b7 = 7'(j);
        in_tag7 = 8'(i * 3 + j);
        @(posedge clk);
        #1;
      end
    in_valid7 = 0;
    drain();
`ifdef KMULMOD_STATS_EN
    chk("stat_ops7", 128'(stat_ops7), 128'(16384));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
